bus_addr_decoder: RTL and testbench

//   CPU-side decoder for the FemtoRV32 memory bus. It maps mem_addr to a one-hot slot select
//   and issues one-cycle read/write strobes to RAM and the six peripherals.
//   It stretches mem_rbusy/mem_wbusy until a multi-cycle slot reports ready.
//   It holds the registered read select that steers the read-data mux.
//   It flags unmapped or timed-out accesses.

---
 rtl/bus_addr_decoder_if.sv | 29 ++
 rtl/bus_addr_decoder.sv | 136 +++++++++++++
 tb/tb_bus_addr_decoder.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_addr_decoder_if.sv
// CPU-side memory bus of the FemtoRV32 as seen by the address decoder.
// Groups the request (address, read pulse, write mask) with the busy replies.
interface bus_addr_decoder_if;
    // Handshake: a request is a one-cycle mem_rstrb pulse or a nonzero mem_wmask.
    // It is taken in the cycle it appears when the decoder is idle. The matching busy
    // flag then rises from the next cycle and stays high until the slot is ready or the
    // access times out. mem_addr must stay stable while busy is high.
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [3:0]  mem_wmask;
    logic        mem_rbusy;
    logic        mem_wbusy;

    modport master (
        output mem_addr,
        output mem_rstrb,
        output mem_wmask,
        input  mem_rbusy,
        input  mem_wbusy
    );

    modport slave (
        input  mem_addr,
        input  mem_rstrb,
        input  mem_wmask,
        output mem_rbusy,
        output mem_wbusy
    );
endinterface

// File: rtl/bus_addr_decoder.sv
// Address decoder for the FemtoRV32 bus: one-hot slot select, read/write strobes,
// busy stretching for multi-cycle slots, read-mux select and sticky error capture.
module bus_addr_decoder #(
    parameter int         PERIPH_BIT = 22,
    parameter int         SEL_LSB    = 16,
    parameter logic [6:0] ZERO_WAIT  = 7'b0010001,
    parameter int         TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 resetn,
    bus_addr_decoder_if.slave    bus,
    input  logic [6:0]           slot_ready,
    input  logic                 err_clr,
    output logic [6:0]           cs,
    output logic [6:0]           cs_rd,
    output logic [6:0]           rd_strobe,
    output logic [6:0]           wr_strobe,
    output logic                 bus_err,
    output logic [31:0]          err_addr,
    output logic [1:0]           fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_R = 2'd1,
        WAIT_W = 2'd2
    } state_t;

    localparam logic [7:0] TMO_MAX = 8'(TIMEOUT);

    state_t      state;
    logic [6:0]  slot_q;
    logic [31:0] addr_q;
    logic [7:0]  cnt;

    logic [3:0]  idx;
    logic        req_w;
    logic        req_r;
    logic        mapped;
    logic        idle;
    logic        accept_r;
    logic        accept_w;
    logic        bad_req;
    logic        no_wait;
    logic        in_wait;
    logic        ready_sel;
    logic        tmo;
    logic        tmo_err;
    logic        err_now;
    logic [31:0] err_src;

    // Slot order is [6]dpram [5]uart [4]gpio [3]mult [2]div [1]bin2bcd [0]RAM.
    assign idx = bus.mem_addr[SEL_LSB+3:SEL_LSB];

    always_comb begin
        cs = '0;
        if (!bus.mem_addr[PERIPH_BIT]) begin
            cs = 7'b0000001;
        end else if (idx < 4'd6) begin
            cs = 7'b1000000 >> idx;
        end
    end

    // A write mask wins over a simultaneous read pulse; the read is simply dropped.
    assign req_w    = |bus.mem_wmask;
    assign req_r    = bus.mem_rstrb & ~req_w;
    assign mapped   = |cs;
    assign idle     = (state == IDLE);
    assign accept_r = idle & req_r & mapped;
    assign accept_w = idle & req_w & mapped;
    assign bad_req  = idle & (req_r | req_w) & ~mapped;
    assign no_wait  = |(cs & (ZERO_WAIT | slot_ready));

    assign in_wait   = (state == WAIT_R) || (state == WAIT_W);
    assign ready_sel = |(slot_q & slot_ready);
    assign tmo       = in_wait & (cnt == TMO_MAX);
    assign tmo_err   = tmo & ~ready_sel;

    assign err_now = bad_req | tmo_err;
    assign err_src = bad_req ? bus.mem_addr : addr_q;

    assign rd_strobe = (accept_r && resetn) ? cs : '0;
    assign wr_strobe = (accept_w && resetn) ? cs : '0;

    assign bus.mem_rbusy = (state == WAIT_R) & ~ready_sel & ~tmo;
    assign bus.mem_wbusy = (state == WAIT_W) & ~ready_sel & ~tmo;

    assign fsm_state = state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            slot_q   <= '0;
            addr_q   <= '0;
            cnt      <= '0;
            cs_rd    <= '0;
            bus_err  <= 1'b0;
            err_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_r) begin
                        cs_rd <= cs;
                    end else if (bad_req && req_r) begin
                        cs_rd <= '0;
                    end
                    if ((accept_r || accept_w) && !no_wait) begin
                        state  <= accept_r ? WAIT_R : WAIT_W;
                        slot_q <= cs;
                        addr_q <= bus.mem_addr;
                        cnt    <= '0;
                    end
                end
                WAIT_R, WAIT_W: begin
                    if (ready_sel || tmo) begin
                        state <= IDLE;
                    end else if (cnt != TMO_MAX) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            // A fresh error beats a clear in the same cycle and re-captures the address.
            if (err_now) begin
                bus_err <= 1'b1;
                if (!bus_err || err_clr) begin
                    err_addr <= err_src;
                end
            end else if (err_clr) begin
                bus_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_addr_decoder.sv
// Bench for bus_addr_decoder: directed bus scenarios followed by random accesses,
// each checked against a transaction-level model of the decoder.
module tb_bus_addr_decoder;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [6:0]  slot_ready;
    logic        err_clr;
    logic [6:0]  cs;
    logic [6:0]  cs_rd;
    logic [6:0]  rd_strobe;
    logic [6:0]  wr_strobe;
    logic        bus_err;
    logic [31:0] err_addr;
    logic [1:0]  fsm_state;

    int errors = 0;
    int checks = 0;

    // Model state: what the read mux select and error capture should hold.
    logic [6:0]  m_cs_rd;
    logic        m_err;
    logic [31:0] m_err_addr;

    bus_addr_decoder_if bus ();

    bus_addr_decoder dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus),
        .slot_ready (slot_ready),
        .err_clr    (err_clr),
        .cs         (cs),
        .cs_rd      (cs_rd),
        .rd_strobe  (rd_strobe),
        .wr_strobe  (wr_strobe),
        .bus_err    (bus_err),
        .err_addr   (err_addr),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Slot of an address: RAM below the peripheral window, else peripheral index 0..5
    // maps to dpram, uart, gpio, mult, div, bin2bcd (bits 6 down to 1).
    function automatic logic [6:0] ref_slot(input logic [31:0] a);
        int pidx;
        if (a[22] == 1'b0) return 7'd1;
        pidx = int'((a >> 16) & 32'hF);
        if (pidx >= 6) return 7'd0;
        return 7'(1 << (6 - pidx));
    endfunction

    // RAM and gpio answer in a single cycle.
    function automatic logic ref_zero_wait(input logic [6:0] slot);
        return (slot == 7'd1) || (slot == 7'd16);
    endfunction

    function automatic logic [31:0] periph_addr(input int pidx, input logic [15:0] low);
        return 32'h0040_0000 | (32'(pidx) << 16) | 32'(low);
    endfunction

    // d = number of wait cycles before the slot raises ready; d < 0 means never.
    task automatic do_access(input string name, input logic [31:0] addr, input logic rd,
                             input logic [3:0] wm, input int d, input logic clr);
        logic [6:0] sel;
        logic       is_w;
        logic       is_r;
        logic       mapped;
        logic       tmo;
        int         exp_busy;
        int         nb;
        int         wrong;
        sel      = ref_slot(addr);
        mapped   = (sel != 7'd0);
        is_w     = (wm != 4'd0);
        is_r     = rd && !is_w;
        exp_busy = 0;
        tmo      = 1'b0;
        if (mapped && !ref_zero_wait(sel)) begin
            if (d < 0) begin
                exp_busy = 255;
                tmo      = 1'b1;
            end else begin
                exp_busy = d;
            end
        end

        @(negedge clk);
        bus.mem_addr  = addr;
        bus.mem_rstrb = rd;
        bus.mem_wmask = wm;
        err_clr       = clr;
        slot_ready    = (7'($urandom) & ~sel) | ((d == 0) ? sel : 7'd0);
        #1;
        check({name, ".cs"}, 32'(cs), 32'(sel));
        check({name, ".rd_strobe"}, 32'(rd_strobe), (is_r && mapped) ? 32'(sel) : 32'd0);
        check({name, ".wr_strobe"}, 32'(wr_strobe), (is_w && mapped) ? 32'(sel) : 32'd0);
        check({name, ".busy_at_req"}, {30'd0, bus.mem_rbusy, bus.mem_wbusy}, 32'd0);

        if (is_r) m_cs_rd = mapped ? sel : 7'd0;
        if (!mapped) begin
            if (!m_err || clr) m_err_addr = addr;
            m_err = 1'b1;
        end else if (clr) begin
            m_err = 1'b0;
        end

        nb    = 0;
        wrong = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            // Requests arriving while the slot is still busy must be ignored.
            bus.mem_rstrb = (k < exp_busy) ? 1'($urandom) : 1'b0;
            bus.mem_wmask = (k < exp_busy) ? 4'($urandom) : 4'd0;
            err_clr       = 1'b0;
            slot_ready    = (7'($urandom) & ~sel) | ((d >= 0 && k >= d) ? sel : 7'd0);
            #1;
            if (rd_strobe != 7'd0 || wr_strobe != 7'd0) wrong++;
            if (is_r ? bus.mem_wbusy : bus.mem_rbusy) wrong++;
            if (is_r ? bus.mem_rbusy : bus.mem_wbusy) nb++;
            else break;
        end
        check({name, ".busy_cycles"}, 32'(nb), 32'(exp_busy));
        check({name, ".no_stray"}, 32'(wrong), 32'd0);

        if (tmo) begin
            if (!m_err) m_err_addr = addr;
            m_err = 1'b1;
        end

        @(negedge clk);
        bus.mem_rstrb = 1'b0;
        bus.mem_wmask = 4'd0;
        slot_ready    = 7'd0;
        #1;
        check({name, ".cs_rd"}, 32'(cs_rd), 32'(m_cs_rd));
        check({name, ".bus_err"}, 32'(bus_err), 32'(m_err));
        check({name, ".err_addr"}, err_addr, m_err_addr);
        check({name, ".idle"}, 32'(fsm_state), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic        rd;
        logic [3:0]  wm;
        int          d;
        int          pick;

        bus.mem_addr  = 32'd0;
        bus.mem_rstrb = 1'b0;
        bus.mem_wmask = 4'd0;
        slot_ready    = 7'd0;
        err_clr       = 1'b0;
        m_cs_rd       = 7'd0;
        m_err         = 1'b0;
        m_err_addr    = 32'd0;

        repeat (3) @(negedge clk);
        check("reset.cs_rd", 32'(cs_rd), 32'd0);
        check("reset.strobes", {18'd0, rd_strobe, wr_strobe}, 32'd0);
        check("reset.busy", {30'd0, bus.mem_rbusy, bus.mem_wbusy}, 32'd0);
        check("reset.bus_err", 32'(bus_err), 32'd0);
        check("reset.err_addr", err_addr, 32'd0);
        check("reset.state", 32'(fsm_state), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        do_access("ram_rd", 32'h0000_0100, 1'b1, 4'd0, 3, 1'b0);
        do_access("mult_wr", 32'h0043_0000, 1'b0, 4'hF, 5, 1'b0);
        do_access("unmapped_rd", 32'h0047_0000, 1'b1, 4'd0, 0, 1'b0);
        do_access("unmapped_wr2", 32'h004F_1234, 1'b0, 4'h1, 0, 1'b0);
        do_access("gpio_rd_clr", periph_addr(2, 16'h0004), 1'b1, 4'd0, 4, 1'b1);
        do_access("dpram_ready_now", periph_addr(0, 16'h0010), 1'b1, 4'd0, 0, 1'b0);
        do_access("div_timeout", 32'h0044_0000, 1'b1, 4'd0, -1, 1'b0);
        do_access("uart_rd_and_wr", 32'h0041_0000, 1'b1, 4'h3, 2, 1'b0);
        do_access("bad_with_clr", 32'h004A_0000, 1'b1, 4'd0, 0, 1'b1);
        do_access("mult_wr_to_clr", 32'h0043_0008, 1'b0, 4'h2, 1, 1'b1);
        do_access("div_wr_timeout", periph_addr(4, 16'h0020), 1'b0, 4'h8, -1, 1'b1);

        for (int n = 0; n < 60; n++) begin
            a    = $urandom;
            pick = $urandom_range(0, 9);
            if (pick < 3) a[22] = 1'b0;
            else if (pick < 9) begin
                a[22]    = 1'b1;
                a[19:16] = 4'($urandom_range(0, 5));
            end else a[22] = 1'b1;
            wm = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            rd = (wm == 4'd0) ? 1'b1 : 1'($urandom);
            d  = ($urandom_range(0, 19) == 0) ? -1 : $urandom_range(0, 12);
            do_access("rand", a, rd, wm, d, $urandom_range(0, 5) == 0);
        end

        // Reset while a bin2bcd read is stalled.
        @(negedge clk);
        bus.mem_addr  = 32'h0045_0000;
        bus.mem_rstrb = 1'b1;
        slot_ready    = 7'd0;
        @(negedge clk);
        bus.mem_rstrb = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_wait.busy_before", 32'(bus.mem_rbusy), 32'd1);
        check("rst_wait.cs_rd_before", 32'(cs_rd), 32'h2);
        @(negedge clk);
        resetn        = 1'b0;
        bus.mem_rstrb = 1'b1;
        #1;
        check("rst_wait.rbusy", 32'(bus.mem_rbusy), 32'd0);
        check("rst_wait.cs_rd", 32'(cs_rd), 32'd0);
        check("rst_wait.state", 32'(fsm_state), 32'd0);
        check("rst_wait.rd_strobe", 32'(rd_strobe), 32'd0);
        check("rst_wait.bus_err", 32'(bus_err), 32'd0);
        @(negedge clk);
        bus.mem_rstrb = 1'b0;
        resetn        = 1'b1;
        m_cs_rd       = 7'd0;
        m_err         = 1'b0;
        m_err_addr    = 32'd0;
        do_access("post_rst_bcd", 32'h0045_0000, 1'b1, 4'd0, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
